// File: rtl/usb_sie_tx_p.sv
// USB serial interface engine, transmit side: SYNC, NRZI with bit stuffing, EOP and abort.
// One byte of holding storage lets the producer stream packets without gaps between bytes.
module usb_sie_tx_p #(
    parameter int CLK_PER_BIT  = 4,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int IDLE_J_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_abort,
    input  logic       ls_mode,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_aborted,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oen
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, ABORT, EOP, IDLE_J} state_t;

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [OW-1:0] ones_cnt;
    logic [7:0]    shift_reg;
    logic [7:0]    hold_data;
    logic [7:0]    bits_left;
    logic          hold_valid;
    logic          abort_pending;
    logic          aborted;
    logic          lvl_j;
    logic          ls_q;

    logic          in_pkt;
    logic          hs;
    logic          abort_now;
    logic          bit_end;
    logic          stuff_due;
    logic [7:0]    load_byte;
    logic          out_bit;
    logic          new_lvl;

    // lvl_j tracks the NRZI level as J/K; ls selects which wire carries J.
    function automatic logic [1:0] enc(input logic j, input logic ls);
        return (j ^ ls) ? 2'b10 : 2'b01;
    endfunction

    assign in_pkt    = (state == SYNC) || (state == DATA);
    assign tx_ready  = in_pkt && !hold_valid && !abort_pending;
    assign hs        = tx_valid && tx_ready && !tx_abort;
    assign abort_now = abort_pending || (tx_abort && in_pkt);
    assign bit_end   = (clk_cnt == CW'(CLK_PER_BIT - 1));
    assign stuff_due = (ones_cnt == OW'(STUFF_LEN));
    assign tx_active = tx_oen;

    // A byte arriving in the very cycle of a byte boundary is sent straight from tx_data.
    always_comb begin
        load_byte = hold_valid ? hold_data : tx_data;
        out_bit   = (bits_left == 8'd0) ? load_byte[0] : shift_reg[0];
        new_lvl   = out_bit ? lvl_j : ~lvl_j;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_oen        <= 1'b0;
            dp_tx         <= 1'b1;
            dn_tx         <= 1'b0;
            tx_done       <= 1'b0;
            tx_aborted    <= 1'b0;
            clk_cnt       <= '0;
            ones_cnt      <= '0;
            shift_reg     <= '0;
            hold_data     <= '0;
            bits_left     <= '0;
            hold_valid    <= 1'b0;
            abort_pending <= 1'b0;
            aborted       <= 1'b0;
            lvl_j         <= 1'b1;
            ls_q          <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_aborted <= 1'b0;
            if (state != IDLE)
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
            if (hs) begin
                hold_data  <= tx_data;
                hold_valid <= 1'b1;
            end
            if (tx_abort && in_pkt)
                abort_pending <= 1'b1;

            case (state)
                IDLE: begin
                    ls_q           <= ls_mode;
                    tx_oen         <= 1'b0;
                    lvl_j          <= 1'b1;
                    {dp_tx, dn_tx} <= enc(1'b1, ls_mode);
                    if (tx_valid) begin
                        // First SYNC bit is a 0, so the line goes straight to K.
                        state          <= SYNC;
                        tx_oen         <= 1'b1;
                        clk_cnt        <= '0;
                        lvl_j          <= 1'b0;
                        {dp_tx, dn_tx} <= enc(1'b0, ls_mode);
                        shift_reg      <= 8'h40;
                        bits_left      <= 8'd7;
                        ones_cnt       <= '0;
                        hold_valid     <= 1'b0;
                        abort_pending  <= 1'b0;
                        aborted        <= 1'b0;
                    end
                end
                SYNC, DATA: if (bit_end) begin
                    if (abort_now) begin
                        state         <= ABORT;
                        bits_left     <= 8'd7;
                        hold_valid    <= 1'b0;
                        abort_pending <= 1'b0;
                        aborted       <= 1'b1;
                    end else if (stuff_due) begin
                        lvl_j          <= ~lvl_j;
                        {dp_tx, dn_tx} <= enc(~lvl_j, ls_q);
                        ones_cnt       <= '0;
                    end else if (bits_left != 8'd0 || hold_valid || hs) begin
                        lvl_j          <= new_lvl;
                        {dp_tx, dn_tx} <= enc(new_lvl, ls_q);
                        ones_cnt       <= out_bit ? ones_cnt + 1'b1 : '0;
                        if (bits_left == 8'd0) begin
                            shift_reg  <= {1'b0, load_byte[7:1]};
                            bits_left  <= 8'd7;
                            hold_valid <= 1'b0;
                            state      <= DATA;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            bits_left <= bits_left - 1'b1;
                        end
                    end else begin
                        state          <= EOP;
                        {dp_tx, dn_tx} <= 2'b00;
                        bits_left      <= 8'(EOP_SE0_BITS - 1);
                    end
                end
                ABORT: if (bit_end) begin
                    if (bits_left != 8'd0) begin
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        state          <= EOP;
                        {dp_tx, dn_tx} <= 2'b00;
                        bits_left      <= 8'(EOP_SE0_BITS - 1);
                    end
                end
                EOP: if (bit_end) begin
                    if (bits_left != 8'd0) begin
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        state          <= IDLE_J;
                        lvl_j          <= 1'b1;
                        {dp_tx, dn_tx} <= enc(1'b1, ls_q);
                        bits_left      <= 8'(IDLE_J_BITS - 1);
                    end
                end
                IDLE_J: if (bit_end) begin
                    if (bits_left != 8'd0) begin
                        bits_left <= bits_left - 1'b1;
                    end else begin
                        state      <= IDLE;
                        tx_oen     <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_aborted <= aborted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_sie_tx_p.md
USB_SIE_TX_P -- requirements
Module: usb_sie_tx_p

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 4, clocks per line bit (legal >=2).
REQ-002 SHALL have parameter STUFF_LEN, default 6, consecutive ones that force a stuffed zero.
REQ-003 SHALL have parameter EOP_SE0_BITS, default 2, SE0 bit times in EOP.
REQ-004 SHALL have parameter IDLE_J_BITS, default 1, J bit times driven after SE0 before release.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-006 SHALL have ports: tx_data input 8 (byte, LSB sent first); tx_valid input 1 (byte/packet request); tx_abort input 1 (one-cycle abort request); ls_mode input 1 (1 = low-speed line polarity).
REQ-007 SHALL have ports: tx_ready output 1 (byte accepted when tx_valid&&tx_ready); tx_active output 1 (equals tx_oen); tx_done output 1 (one-cycle pulse at packet end); tx_aborted output 1 (high with tx_done if packet was aborted).
REQ-008 SHALL have ports: dp_tx output 1; dn_tx output 1; tx_oen output 1 (line drive enable); all three registered.

Function
REQ-009 SHALL implement states IDLE, SYNC, DATA, ABORT, EOP, IDLE_J.
REQ-010 SHALL define J = {dp,dn} 10 and K = 01 when ls_mode=0, and swapped when ls_mode=1; SE0 = 00.
REQ-011 SHALL sample ls_mode only in IDLE and hold it constant for the whole packet.
REQ-012 SHALL, in IDLE, drive tx_oen=0 and {dp,dn}=J of current ls_mode.
REQ-013 SHALL leave IDLE when tx_valid=1; tx_oen=1 and first SYNC bit (K) on the line in the next cycle.
REQ-014 SHALL hold every line bit for exactly CLK_PER_BIT cycles; bit boundaries come from a counter cleared on IDLE exit.
REQ-015 SHALL send SYNC as 8'h80 LSB first (KJKJKJKK), NRZI-encoded from initial level J.
REQ-016 SHALL NRZI-encode: a 0 toggles the line level; a 1 keeps it.
REQ-017 SHALL count consecutive ones including SYNC bits; after STUFF_LEN ones insert one 0 bit time, stalling the data shifter; counter clears on any 0.
REQ-018 SHALL stuff after the last data bit, before EOP, if the count reaches STUFF_LEN there.
REQ-019 SHALL provide a one-byte holding register; tx_ready = (state SYNC or DATA) && hold empty && !abort_pending, combinational.
REQ-020 SHALL move hold to shifter at each byte boundary; if hold empty at boundary (first boundary = SYNC end), enter EOP.
REQ-021 SHALL make exactly one handshake per byte; tx_data ignored when no handshake.
REQ-022 SHALL, in EOP, drive SE0 for EOP_SE0_BITS bit times, then J for IDLE_J_BITS bit times (IDLE_J), then enter IDLE.
REQ-023 SHALL assert tx_done on the first cycle tx_oen=0 after a packet; tx_aborted the same cycle when applicable.
REQ-024 SHALL, on tx_abort in SYNC or DATA, finish the current bit, discard hold and shifter, then send 8 bit times of 1 with stuffing disabled (no transitions), then EOP.
REQ-025 SHALL ignore tx_abort in IDLE, ABORT, EOP, IDLE_J; tx_abort together with a handshake: abort wins, byte dropped.
REQ-026 SHALL ignore tx_valid in EOP/IDLE_J; a new packet needs tx_valid=1 in IDLE.

Reset
REQ-027 SHALL, on rst at any time including mid-packet, on the next edge set: state IDLE, tx_oen=0, dp_tx=1, dn_tx=0, tx_ready=0, tx_active=0, tx_done=0, tx_aborted=0, hold empty, stuff count 0, bit counter 0.
REQ-028 SHALL not emit tx_done for a packet terminated by rst.

Verification
REQ-029 SHALL cover: FS, one byte 0xC3 -> line KJKJKJKK, KKJKJKKK, SE0 SE0 J; tx_oen high 76 cycles; one handshake; tx_done one cycle.
REQ-030 SHALL cover: one byte 0xFF -> stuffed 0 after 5th data bit; 17 bits before EOP; tx_oen high 80 cycles.
REQ-031 SHALL cover: 3 bytes streamed, tx_valid held -> exactly 3 handshakes, no gaps between bytes, EOP after byte 3.
REQ-032 SHALL cover: tx_abort mid byte 2 -> current bit completes, 8 constant-level bits, SE0 SE0 J, tx_done=tx_aborted=1.
REQ-033 SHALL cover: ls_mode=1 -> idle {dp,dn}=01, first SYNC bit 10; toggling ls_mode mid-packet has no effect.
REQ-034 SHALL cover: rst mid-DATA -> next cycle tx_oen=0, {dp,dn}=10, tx_ready=0, no tx_done; next tx_valid starts clean SYNC.
